shock_scheduler: RTL
====================

# shock_scheduler

Shares the single shock power stage among `NUM_REQ` requesters (player channels, penalty events). It latches rising-edge requests as per-requester pending counts and grants them round-robin. For each grant it drives one fixed-length shock pulse, then enforces a cooldown gap before the next grant. It sits between the game logic and the shock output pin, and is the only block allowed to drive `o_shock`.

## Interface
- `NUM_REQ`, 4: number of requesters; must be ≥ 2.
- `PULSE_CYC`, 16777216: shock pulse length in `i_clk` cycles; must be ≥ 1.
- `GAP_CYC`, 4194304: mandatory cooldown after every pulse, in cycles; must be ≥ 1.
- `MAX_PEND`, 3: saturation limit of each pending counter; must be ≥ 1.
- `i_clk` in 1: system clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_req` in `NUM_REQ`: level request lines. Only a rising edge (0→1 between consecutive samples) counts as one request.
- `i_enable` in 1: global enable. Low disables granting and clears pending requests.
- `o_shock` in/out: out 1: drive to the shock power stage.
- `o_grant` out `NUM_REQ`: one-hot owner of the current pulse; all zero outside SHOCK.
- `o_busy` out 1: high whenever the state is not IDLE.
- `o_pending` out `NUM_REQ`: bit i is high when requester i's pending count is nonzero.
- `o_drop` out 1: one-cycle pulse when a request edge is discarded because of saturation.

## Operation
- Edge detect: a per-bit `req_d` register, reset to 0. An edge on bit i exists in a cycle when `i_req[i] & ~req_d[i]`. The pending count is updated at the same clock edge.
- Pending count `pend[i]` has width `$clog2(MAX_PEND+1)`. It updates as follows:
  - +1 on an edge.
  - −1 when granted.
  - Both in the same cycle: unchanged.
  - Edge while at `MAX_PEND` with no simultaneous grant: unchanged, and `o_drop` = 1 for the next cycle.
  - Multiple requesters dropping in the same cycle produce a single `o_drop` pulse.
- Round-robin pointer `last`, reset to `NUM_REQ-1`.
  - Search order is `last+1`, `last+2`, … modulo `NUM_REQ`; the first nonzero `pend` wins.
  - `last` is updated to the winner on grant.
- States:
  - IDLE: if `i_enable` and any `pend` is nonzero, choose the winner combinationally, decrement its count, latch the one-hot grant, clear the counter, and go to SHOCK.
  - SHOCK: `o_shock` = 1. Counter increments each cycle. When counter = `PULSE_CYC-1`, clear the counter and go to GAP.
  - GAP: `o_shock` = 0. Counter increments each cycle. When counter = `GAP_CYC-1`, clear the counter and go to IDLE.
- Counter width is `$clog2(max(PULSE_CYC,GAP_CYC))`, with a minimum of 1 bit. There is no wrap-around inside a state.
- `i_enable` low:
  - All `pend` are cleared and new edges are ignored; `req_d` still tracks `i_req`.
  - IDLE does not grant.
  - In SHOCK the pulse is truncated: the next state is GAP with the counter cleared, and `o_grant` is cleared.
  - GAP always runs to completion, so cooldown is never skipped.
- `o_shock`, `o_grant` and `o_busy` are registered, or decoded from registered state only; they carry no combinational path from inputs.

## Timing
- Reset values: `o_shock` = 0, `o_grant` = 0, `o_busy` = 0, `o_pending` = 0, `o_drop` = 0, state IDLE, counter 0, `last` = `NUM_REQ-1`.
- Request latency:
  - The edge is sampled at clock edge k, so `pend` is nonzero after k.
  - From an idle, enabled scheduler, SHOCK is entered at k+1: `o_shock` and `o_grant` are high from edge k+1 through edge k+`PULSE_CYC`.
- `o_shock` is high for exactly `PULSE_CYC` cycles per grant unless truncated.
- Back-to-back grants: the rising edges of successive pulses are exactly `PULSE_CYC+GAP_CYC+1` cycles apart (one IDLE cycle for arbitration).
- `o_pending` reflects `pend` registers one cycle after the edge. A granted requester's bit drops on the edge entering SHOCK if its count reached 0.
- Asynchronous reset mid-pulse forces `o_shock` low immediately, with no cooldown.

## Test plan
Bench parameters: `NUM_REQ`=4, `PULSE_CYC`=8, `GAP_CYC`=4, `MAX_PEND`=2.
1. Single request: `i_req[2]` rises, sampled at edge 10 → `o_shock`=1 and `o_grant`=4'b0100 over edges 11–18; `o_busy` high over edges 11–22; IDLE at 23.
2. Simultaneous requests: `i_req[0]` and `i_req[3]` rise together after reset → grant 0 first, then grant 3. `o_shock` rising edges are 13 cycles apart; the order is 0 then 3.
3. Saturation: during requester 0's pulse, toggle `i_req[1]` for 4 edges → `pend[1]` reaches 2; 2 `o_drop` pulses; exactly 2 further pulses for requester 1.
4. Level hold: `i_req[1]` held high for 100 cycles → exactly one pulse.
5. Enable drop: deassert `i_enable` on SHOCK cycle 3 with `pend[2]`=1 → `o_shock` low on the next edge, full 4-cycle GAP, then IDLE with no grant and `o_pending`=0.
6. Async reset: assert `i_rst_n`=0 mid-SHOCK → all outputs 0 immediately. After release, a new `i_req[0]` edge is granted with `o_grant`=4'b0001.

Source files
------------

// File: rtl/shock_scheduler_if.sv
// Request/status bundle between the game logic and shock_scheduler.
// The master side drives requests and enable; the slave is the scheduler.
interface shock_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] i_req;
  logic               i_enable;
  logic               o_shock;
  logic [NUM_REQ-1:0] o_grant;
  logic               o_busy;
  logic [NUM_REQ-1:0] o_pending;
  logic               o_drop;

  modport master (
    output i_req, i_enable,
    input  o_shock, o_grant, o_busy,
    input  o_pending, o_drop
  );

  modport slave (
    input  i_req, i_enable,
    output o_shock, o_grant, o_busy,
    output o_pending, o_drop
  );
endinterface

// File: rtl/shock_scheduler.sv
// Round-robin arbiter for the single shock power stage.
// Edge-counted requests, fixed pulse, mandatory cooldown gap.
module shock_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int PULSE_CYC = 16777216,
  parameter int GAP_CYC   = 4194304,
  parameter int MAX_PEND  = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  shock_scheduler_if.slave  bus
);

  localparam int PW   = $clog2(MAX_PEND + 1);
  localparam int LW   = $clog2(NUM_REQ);
  localparam int MAXC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOCK = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [LW-1:0]      last_q, last_d;
  logic [NUM_REQ-1:0] req_q, req_d;
  logic [PW-1:0]      pend_q [NUM_REQ];
  logic [PW-1:0]      pend_d [NUM_REQ];
  logic               drop_q, drop_d;

  logic [NUM_REQ-1:0] edge_v;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               win_found;
  logic [LW-1:0]      win_idx;
  logic [LW-1:0]      cand;
  int                 cand_i;
  logic               grant_go;

  assign req_d  = bus.i_req;
  assign edge_v = bus.i_req & ~req_q & {NUM_REQ{bus.i_enable}};

  // Search starts just after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_i    = 0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_i = int'(last_q) + k;
      if (cand_i >= NUM_REQ) cand_i = cand_i - NUM_REQ;
      cand = LW'(cand_i);
      if (!win_found && pend_q[cand] != '0) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign grant_go = (state_q == IDLE) && bus.i_enable && win_found;
  assign gnt_oh   = grant_go ? (NUM_REQ'(1) << win_idx) : '0;

  always_comb begin
    drop_d = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_d[i] = pend_q[i];
      if (!bus.i_enable) begin
        pend_d[i] = '0;
      end else if (edge_v[i] && !gnt_oh[i]) begin
        if (pend_q[i] == PW'(MAX_PEND)) drop_d = 1'b1;
        else pend_d[i] = pend_q[i] + PW'(1);
      end else if (!edge_v[i] && gnt_oh[i]) begin
        pend_d[i] = pend_q[i] - PW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      last_q  <= LW'(NUM_REQ - 1);
      req_q   <= '0;
      drop_q  <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) pend_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      req_q   <= req_d;
      drop_q  <= drop_d;
      for (int i = 0; i < NUM_REQ; i++) pend_q[i] <= pend_d[i];
    end
  end

  // Disable truncates a pulse but never shortens the cooldown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (grant_go) begin
          state_d = SHOCK;
          cnt_d   = '0;
          grant_d = gnt_oh;
          last_d  = win_idx;
        end
      end
      SHOCK: begin
        if (!bus.i_enable || cnt_q == CW'(PULSE_CYC - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
          grant_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == CW'(GAP_CYC - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    bus.o_shock = (state_q == SHOCK);
    bus.o_busy  = (state_q != IDLE);
    bus.o_grant = grant_q;
    bus.o_drop  = drop_q;
    for (int i = 0; i < NUM_REQ; i++) bus.o_pending[i] = |pend_q[i];
  end

endmodule
